// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - line, tick and read-side bus bundle for the UART receiver
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 brg_en;
    logic                 rxd;
    logic                 rd_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output brg_en, rxd, rd_ack,
        input  rx_data, rda, frame_err, overrun, busy
    );

    modport slave (
        input  brg_en, rxd, rd_ack,
        output rx_data, rda, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: sync, start detect, mid-bit sampling, stop check
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [SYNC_STAGES-1:0] sync;
    logic                 rxd_s;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rda_q;
    logic                 ferr_q;
    logic                 ovr_q;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 load;

    assign rxd_s = sync[SYNC_STAGES-1];

    always_comb begin
        state_nx = state;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        load     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxd_s) state_nx = S_START;
            end
            S_START: begin
                // a start bit still low at its middle is genuine; otherwise a glitch
                if (bus.brg_en) begin
                    if (tick_cnt == HALF_CNT) state_nx = rxd_s ? S_IDLE : S_DATA;
                    else                      cnt_inc  = 1'b1;
                end
            end
            S_DATA: begin
                if (bus.brg_en) begin
                    if (tick_cnt == FULL_CNT) begin
                        shift_en = 1'b1;
                        cnt_clr  = 1'b1;
                        if (bit_cnt == LAST_BIT) state_nx = S_STOP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bus.brg_en) begin
                    if (tick_cnt == FULL_CNT) begin
                        load     = 1'b1;
                        state_nx = rxd_s ? S_IDLE : S_BREAK;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rxd_s) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            sync     <= '1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            state <= state_nx;
            sync  <= {sync[SYNC_STAGES-2:0], bus.rxd};
            if (state_nx != state || cnt_clr) tick_cnt <= '0;
            else if (cnt_inc)                 tick_cnt <= tick_cnt + CW'(1);
            if (state != S_DATA) bit_cnt <= '0;
            else if (shift_en)   bit_cnt <= bit_cnt + BW'(1);
            if (shift_en) shift <= {rxd_s, shift[DATA_BITS-1:1]};
        end
    end

    // a load in the same cycle as a read keeps the flag up: the old byte was consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else if (load) begin
            rx_data_q <= shift;
            ferr_q    <= ~rxd_s;
            rda_q     <= 1'b1;
            ovr_q     <= rda_q & ~bus.rd_ack;
        end else if (bus.rd_ack) begin
            rda_q <= 1'b0;
            ovr_q <= 1'b0;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rda       = rda_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    uart_rx_if #(.DATA_BITS(DB)) bus ();

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            tick;
        logic [DB-1:0] data;
        logic          ferr;
    } load_t;

    load_t         pend[$];
    logic          m_rda  = 1'b0;
    logic          m_ferr = 1'b0;
    logic          m_ovr  = 1'b0;
    logic [DB-1:0] m_data = '0;
    logic          rda_prev = 1'b0;
    int            rise_cyc = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // frame-level model: a byte lands at the edge ending its load-tick cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_rda  = 1'b0;
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
            m_data = '0;
            pend.delete();
        end else if (pend.size() > 0 && pend[0].tick == cyc) begin
            m_ovr  = m_rda && !bus.rd_ack;
            m_rda  = 1'b1;
            m_data = pend[0].data;
            m_ferr = pend[0].ferr;
            void'(pend.pop_front());
        end else if (bus.rd_ack) begin
            m_rda = 1'b0;
            m_ovr = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("rda", 32'(bus.rda), 32'(m_rda));
        chk("rx_data", 32'(bus.rx_data), 32'(m_data));
        chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        if (bus.rda && !rda_prev) rise_cyc = cyc;
        rda_prev = bus.rda;
    end

    initial begin
        bus.brg_en = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.brg_en = (cyc % TICK_DIV == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // cycle of the n-th tick at or after cycle 'from'
    function automatic int nth_tick(input int from, input int n);
        int c = from;
        int k = 0;
        while (k < n) begin
            if (c % TICK_DIV == 0) k++;
            if (k < n) c++;
        end
        return c;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input int ack_mode);
        repeat (n) begin
            next_cycle();
            bus.rxd    = 1'b1;
            bus.rd_ack = (ack_mode != 0) ? ($urandom_range(0, 99) < 4) : 1'b0;
        end
    endtask

    task automatic pulse_ack();
        next_cycle();
        bus.rd_ack = 1'b1;
        next_cycle();
        bus.rd_ack = 1'b0;
    endtask

    // ack_mode: 0 none, 1 random, 2 pulse exactly in the load-tick cycle
    task automatic send_frame(input logic [DB-1:0] data, input logic stop, input int n_bits,
                              input int ack_mode, output int t_load, output int f_cyc);
        int   last;
        logic val;
        last   = (n_bits < DB) ? n_bits : DB + 1;
        t_load = 0;
        f_cyc  = 0;
        for (int b = 0; b <= last; b++) begin
            if (b == 0)       val = 1'b0;
            else if (b <= DB) val = data[b-1];
            else              val = stop;
            for (int k = 0; k < BIT_CLKS; k++) begin
                next_cycle();
                if (b == 0 && k == 0) begin
                    f_cyc  = cyc;
                    t_load = nth_tick(cyc + 3, OS / 2 + OS * (DB + 1));
                    pend.push_back('{t_load, data, ~stop});
                end
                bus.rxd = val;
                case (ack_mode)
                    1:       bus.rd_ack = ($urandom_range(0, 99) < 2);
                    2:       bus.rd_ack = (cyc == t_load);
                    default: bus.rd_ack = 1'b0;
                endcase
            end
        end
    endtask

    initial begin
        int t_load;
        int f_cyc;
        logic stop;
        bus.rxd    = 1'b1;
        bus.rd_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_rx_data", 32'(bus.rx_data), 0);

        // clean 8N1 byte and its read
        idle(100, 0);
        send_frame(8'hA5, 1'b1, DB, 0, t_load, f_cyc);
        chk("load_latency_in_range", 32'((t_load - f_cyc) >= 607 && (t_load - f_cyc) <= 610), 1);
        chk("rda_rise_cycle", 32'(rise_cyc), 32'(t_load + 1));
        idle(5, 0);
        @(negedge clk);
        chk("t1_data", 32'(bus.rx_data), 32'h0A5);
        chk("t1_rda", 32'(bus.rda), 1);
        chk("t1_ferr", 32'(bus.frame_err), 0);
        chk("t1_ovr", 32'(bus.overrun), 0);
        pulse_ack();
        @(negedge clk);
        chk("t1_rda_after_ack", 32'(bus.rda), 0);

        // short low glitch on an idle line
        idle(50, 0);
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            bus.rxd = 1'b0;
            if (k == 10) begin
                @(negedge clk);
                chk("t2_busy_in_start", 32'(bus.busy), 1);
            end
        end
        idle(60, 0);
        @(negedge clk);
        chk("t2_busy_after_glitch", 32'(bus.busy), 0);
        chk("t2_rda", 32'(bus.rda), 0);

        // framing error followed by a held-low line
        send_frame(8'h3C, 1'b0, DB, 0, t_load, f_cyc);
        for (int k = 0; k < 200; k++) begin
            next_cycle();
            bus.rxd = 1'b0;
            if (k == 100) begin
                @(negedge clk);
                chk("t3_busy_break", 32'(bus.busy), 1);
                chk("t3_data", 32'(bus.rx_data), 32'h03C);
                chk("t3_ferr", 32'(bus.frame_err), 1);
            end
        end
        idle(10, 0);
        @(negedge clk);
        chk("t3_busy_released", 32'(bus.busy), 0);
        chk("t3_pending_none", 32'(pend.size()), 0);
        pulse_ack();

        // back-to-back bytes without a read
        idle(20, 0);
        send_frame(8'h11, 1'b1, DB, 0, t_load, f_cyc);
        send_frame(8'h22, 1'b1, DB, 0, t_load, f_cyc);
        idle(2, 0);
        @(negedge clk);
        chk("t4_data", 32'(bus.rx_data), 32'h022);
        chk("t4_ovr", 32'(bus.overrun), 1);
        pulse_ack();
        @(negedge clk);
        chk("t4_rda_cleared", 32'(bus.rda), 0);
        chk("t4_ovr_cleared", 32'(bus.overrun), 0);

        // read of the previous byte in the exact load cycle
        idle(20, 0);
        send_frame(8'h11, 1'b1, DB, 0, t_load, f_cyc);
        idle(20, 0);
        send_frame(8'h55, 1'b1, DB, 2, t_load, f_cyc);
        idle(2, 0);
        @(negedge clk);
        chk("t5_rda", 32'(bus.rda), 1);
        chk("t5_ovr", 32'(bus.overrun), 0);
        chk("t5_data", 32'(bus.rx_data), 32'h055);

        // reset after four data bits
        send_frame(8'hC3, 1'b1, 4, 0, t_load, f_cyc);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_rda", 32'(bus.rda), 0);
        chk("t6_rst_data", 32'(bus.rx_data), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        bus.rxd = 1'b1;
        repeat (5) next_cycle();
        rst = 1'b1;
        idle(20, 0);
        send_frame(8'h81, 1'b1, DB, 0, t_load, f_cyc);
        idle(2, 0);
        @(negedge clk);
        chk("t6_data", 32'(bus.rx_data), 32'h081);
        chk("t6_rda", 32'(bus.rda), 1);
        chk("t6_ferr", 32'(bus.frame_err), 0);
        chk("t6_ovr", 32'(bus.overrun), 0);

        // random traffic with random reads
        for (int n = 0; n < 40; n++) begin
            stop = ($urandom_range(0, 7) != 0);
            send_frame(8'($urandom_range(0, 255)), stop, DB, 1, t_load, f_cyc);
            idle(stop ? $urandom_range(0, 80) : $urandom_range(4, 80), 1);
        end
        idle(20, 0);
        @(negedge clk);
        chk("final_pending_none", 32'(pend.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
